// File: rtl/run_seq_pkg.sv
// Shared types and constants for the run sequencer.
//   seq_state_t : sequencer FSM states (2-bit encoding)
//   CNT_W       : width of the RUN cycle counter and of rpt_cycles
//   CNT_MAX     : saturation value of the RUN cycle counter
package run_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } seq_state_t;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/run_sequencer_sat_counter.sv
// Saturating up-counter used to measure RUN clocks.
// Ports:
//   clk_i  : clock, posedge
//   rst_i  : asynchronous active-high reset (count -> 0)
//   clr_i  : synchronous clear, has priority over enable
//   en_i   : count enable; the count holds at all-ones instead of wrapping
//   cnt_o  : current count
module sat_counter
    import run_seq_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/run_sequencer.sv
// Run controller for the 9-bit core. Accepts a run request (valid/ready),
// pulses the core Start pin for START_CYCLES clocks, counts RUN clocks until
// the core raises Ack or TIMEOUT expires, then presents a report (valid/ready).
// Ports:
//   Clk, Reset              : clock (posedge) and asynchronous active-high reset
//   req_valid/req_ready     : run request handshake; req_tag captured on accept
//   core_start / core_ack   : core Start output and Ack (done) input
//   rpt_valid/rpt_ready     : report handshake
//   rpt_cycles/rpt_timeout/rpt_tag : report payload, stable while rpt_valid
//   busy                    : high whenever the sequencer is not idle
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int unsigned START_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 60000,
    parameter int unsigned TAG_W        = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TAG_W-1:0] req_tag,
    output logic             core_start,
    input  logic             core_ack,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_cycles,
    output logic             rpt_timeout,
    output logic [TAG_W-1:0] rpt_tag,
    output logic             busy
);

    // START down-counter is loaded with START_CYCLES-1 and exits at zero.
    localparam int unsigned SC_LOAD = (START_CYCLES > 1) ? START_CYCLES - 1 : 0;
    localparam int          SC_W    = (SC_LOAD > 0) ? $clog2(SC_LOAD + 1) : 1;

    // Timeout is kept below the counter saturation value so a timed-out
    // report can never be confused with a saturated count.
    localparam int unsigned TO_CLAMP = (TIMEOUT > 32'hFFFE) ? 32'hFFFE :
                                       ((TIMEOUT < 1) ? 1 : TIMEOUT);
    localparam logic [CNT_W-1:0] TO_EFF  = CNT_W'(TO_CLAMP);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_CLAMP - 1);

    seq_state_t        state_q, state_d;
    logic [SC_W-1:0]   start_cnt_q, start_cnt_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [CNT_W-1:0]  rpt_cycles_q, rpt_cycles_d;
    logic              rpt_timeout_q, rpt_timeout_d;
    logic              cnt_clr;
    logic              cnt_en;
    logic [CNT_W-1:0]  run_cnt;

    sat_counter #(
        .W (CNT_W)
    ) u_run_cnt (
        .clk_i (Clk),
        .rst_i (Reset),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (run_cnt)
    );

    always_comb begin
        state_d       = state_q;
        start_cnt_d   = start_cnt_q;
        tag_d         = tag_q;
        rpt_cycles_d  = rpt_cycles_q;
        rpt_timeout_d = rpt_timeout_q;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    tag_d       = req_tag;
                    cnt_clr     = 1'b1;
                    start_cnt_d = SC_W'(SC_LOAD);
                    state_d     = START;
                end
            end
            START: begin
                // Ack is not looked at here: it may still be high from the
                // previous program until the core sees the new Start.
                if (start_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    start_cnt_d = start_cnt_q - SC_W'(1);
                end
            end
            RUN: begin
                // Ack is tested first so it wins over a coincident timeout.
                if (core_ack) begin
                    state_d       = REPORT;
                    rpt_cycles_d  = run_cnt;
                    rpt_timeout_d = 1'b0;
                end else if (run_cnt == TO_LAST) begin
                    state_d       = REPORT;
                    rpt_cycles_d  = TO_EFF;
                    rpt_timeout_d = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            REPORT: begin
                if (rpt_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= IDLE;
            start_cnt_q   <= '0;
            tag_q         <= '0;
            rpt_cycles_q  <= '0;
            rpt_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_cnt_q   <= start_cnt_d;
            tag_q         <= tag_d;
            rpt_cycles_q  <= rpt_cycles_d;
            rpt_timeout_q <= rpt_timeout_d;
        end
    end

    // Handshake and status outputs decode straight from the state register so
    // an asynchronous reset drops them without waiting for a clock.
    assign req_ready   = (state_q == IDLE);
    assign core_start  = (state_q == START);
    assign rpt_valid   = (state_q == REPORT);
    assign busy        = (state_q != IDLE);
    assign rpt_cycles  = rpt_cycles_q;
    assign rpt_timeout = rpt_timeout_q;
    assign rpt_tag     = tag_q;

endmodule

// File: tb/tb_run_sequencer.sv
module tb_run_sequencer;

    localparam int START_CYCLES = 2;
    localparam int TIMEOUT      = 20;
    localparam int TAG_W        = 4;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             req_valid;
    logic             req_ready;
    logic [TAG_W-1:0] req_tag;
    logic             core_start;
    logic             core_ack;
    logic             rpt_valid;
    logic             rpt_ready;
    logic [15:0]      rpt_cycles;
    logic             rpt_timeout;
    logic [TAG_W-1:0] rpt_tag;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    run_sequencer #(
        .START_CYCLES (START_CYCLES),
        .TIMEOUT      (TIMEOUT),
        .TAG_W        (TAG_W)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_tag     (req_tag),
        .core_start  (core_start),
        .core_ack    (core_ack),
        .rpt_valid   (rpt_valid),
        .rpt_ready   (rpt_ready),
        .rpt_cycles  (rpt_cycles),
        .rpt_timeout (rpt_timeout),
        .rpt_tag     (rpt_tag),
        .busy        (busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0] tag;
        int         ack_at;      // RUN clock index where Ack rises, -1 = never
        bit         stale;       // Ack already high before the request
        int         exp_cycles;
        bit         exp_to;
        int         exp_runclks; // RUN clocks spent before REPORT
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a request at a negedge; returns at the negedge after the accept edge.
    task automatic issue_req(input logic [3:0] tag);
        req_valid = 1'b1;
        req_tag   = tag;
        check("req_ready_idle", 32'(req_ready), 1);
        @(negedge Clk);
        req_valid = 1'b0;
        check("start_latency", 32'(core_start), 1);
    endtask

    // Starts in the first START clock; returns in the first REPORT clock.
    task automatic finish_run(input int ack_at, output int runclks);
        int  sc;
        bit  done;
        sc = 0;
        while (core_start === 1'b1 && sc < 10) begin
            check("no_rpt_in_start", 32'(rpt_valid), 0);
            sc++;
            @(negedge Clk);
        end
        check("start_len", sc, START_CYCLES);
        check("start_low_in_run", 32'(core_start), 0);
        runclks = 0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            core_ack = (ack_at >= 0 && k >= ack_at);
            @(negedge Clk);
            if (rpt_valid === 1'b1) begin
                done    = 1'b1;
                runclks = k + 1;
            end
        end
        if (!done) check("run_bound_expired", 0, 1);
    endtask

    task automatic pop_report();
        rpt_ready = 1'b1;
        @(negedge Clk);
        rpt_ready = 1'b0;
        check("pop_rpt_valid", 32'(rpt_valid), 0);
        check("pop_req_ready", 32'(req_ready), 1);
        check("pop_busy", 32'(busy), 0);
    endtask

    initial begin
        int rc;

        vecs[0] = '{4'h3, 10, 1'b0, 10, 1'b0, 11};
        vecs[1] = '{4'h2,  0, 1'b1,  0, 1'b0,  1};
        vecs[2] = '{4'h5,  0, 1'b0,  0, 1'b0,  1};
        vecs[3] = '{4'hA,  1, 1'b0,  1, 1'b0,  2};
        vecs[4] = '{4'hC, -1, 1'b0, 20, 1'b1, 20};
        vecs[5] = '{4'h7, 19, 1'b0, 19, 1'b0, 20};
        vecs[6] = '{4'h9, 18, 1'b0, 18, 1'b0, 19};
        vecs[7] = '{4'hF, 20, 1'b0, 20, 1'b1, 20};

        Reset     = 1'b1;
        req_valid = 1'b0;
        req_tag   = '0;
        core_ack  = 1'b0;
        rpt_ready = 1'b0;

        // Reset state
        @(negedge Clk);
        check("rst_core_start", 32'(core_start), 0);
        check("rst_rpt_valid", 32'(rpt_valid), 0);
        check("rst_rpt_cycles", 32'(rpt_cycles), 0);
        check("rst_rpt_timeout", 32'(rpt_timeout), 0);
        check("rst_rpt_tag", 32'(rpt_tag), 0);
        check("rst_busy", 32'(busy), 0);
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_req_ready", 32'(req_ready), 1);

        // Table-driven runs
        for (int i = 0; i < 8; i++) begin
            core_ack = vecs[i].stale;
            issue_req(vecs[i].tag);
            finish_run(vecs[i].ack_at, rc);
            check("run_clocks", rc, vecs[i].exp_runclks);
            check("rpt_cycles", 32'(rpt_cycles), vecs[i].exp_cycles);
            check("rpt_timeout", 32'(rpt_timeout), 32'(vecs[i].exp_to));
            check("rpt_tag", 32'(rpt_tag), 32'(vecs[i].tag));
            check("rpt_req_ready", 32'(req_ready), 0);
            check("rpt_busy", 32'(busy), 1);
            $display("txn %0d tag=%0h cycles=%0d timeout=%0d run_clocks=%0d",
                     i, rpt_tag, rpt_cycles, rpt_timeout, rc);
            pop_report();
            core_ack = 1'b0;
        end

        // Report back-pressure with a new request waiting
        issue_req(4'h6);
        finish_run(3, rc);
        check("bp_cycles", 32'(rpt_cycles), 3);
        req_valid = 1'b1;
        req_tag   = 4'hB;
        for (int j = 0; j < 5; j++) begin
            check("bp_rpt_valid", 32'(rpt_valid), 1);
            check("bp_req_ready", 32'(req_ready), 0);
            check("bp_cycles_stable", 32'(rpt_cycles), 3);
            check("bp_timeout_stable", 32'(rpt_timeout), 0);
            check("bp_tag_stable", 32'(rpt_tag), 32'h6);
            @(negedge Clk);
        end
        rpt_ready = 1'b1;
        @(negedge Clk);
        rpt_ready = 1'b0;
        check("bp_idle_rpt_valid", 32'(rpt_valid), 0);
        check("bp_idle_req_ready", 32'(req_ready), 1);
        @(negedge Clk);
        req_valid = 1'b0;
        check("bp_accept_next", 32'(core_start), 1);
        finish_run(0, rc);
        check("bp_new_tag", 32'(rpt_tag), 32'hB);
        check("bp_new_cycles", 32'(rpt_cycles), 0);
        $display("txn bp tag=%0h cycles=%0d timeout=%0d", rpt_tag, rpt_cycles, rpt_timeout);
        pop_report();
        core_ack = 1'b0;

        // Reset during RUN at counter=7
        issue_req(4'hD);
        repeat (9) @(negedge Clk);
        check("mid_busy", 32'(busy), 1);
        check("mid_core_start", 32'(core_start), 0);
        #2 Reset = 1'b1;
        #1;
        check("rstrun_core_start", 32'(core_start), 0);
        check("rstrun_rpt_valid", 32'(rpt_valid), 0);
        check("rstrun_busy", 32'(busy), 0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("rstrun_req_ready", 32'(req_ready), 1);
        check("rstrun_rpt_cycles", 32'(rpt_cycles), 0);
        check("rstrun_rpt_tag", 32'(rpt_tag), 0);
        $display("txn reset-in-run tag=D discarded");

        // Reset during START drops core_start without a clock edge
        issue_req(4'h1);
        #2 Reset = 1'b1;
        #1;
        check("rststart_core_start", 32'(core_start), 0);
        check("rststart_busy", 32'(busy), 0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        $display("txn reset-in-start tag=1 discarded");

        // Recovery run
        issue_req(4'h8);
        finish_run(5, rc);
        check("rec_cycles", 32'(rpt_cycles), 5);
        check("rec_tag", 32'(rpt_tag), 32'h8);
        check("rec_timeout", 32'(rpt_timeout), 0);
        $display("txn recovery tag=%0h cycles=%0d timeout=%0d", rpt_tag, rpt_cycles, rpt_timeout);
        pop_report();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Upstream run controller for the 9-bit core. It accepts a run request via valid/ready and drives the core's Start pulse.
- It then counts clocks until the core raises Ack, or until a timeout expires.
- The result (cycle count, timeout flag, echoed tag) is returned via a valid/ready report channel.
- Sits between the bench/host side and the core's Start/Ack pins.

Parameters:
- START_CYCLES, 2, number of clocks core_start is held high (min 1).
- TIMEOUT, 16'd60000, max RUN clocks before aborting with timeout.
- TAG_W, 4, width of request tag echoed in report.

Ports:
- Clk  input  1  clock, posedge only.
- Reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  host requests a program run.
- req_ready  output  1  sequencer can accept a request (high only in IDLE).
- req_tag  input  TAG_W  host label for the run, captured on accept.
- core_start  output  1  drives core Start.
- core_ack  input  1  core Ack (done flag).
- rpt_valid  output  1  report available.
- rpt_ready  input  1  host consumes report.
- rpt_cycles  output  16  RUN clock count, saturating at 16'hFFFF.
- rpt_timeout  output  1  run aborted by timeout.
- rpt_tag  output  TAG_W  captured req_tag.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync deassert at the design level):
  - State=IDLE.
  - core_start=0, rpt_valid=0, rpt_cycles=0, rpt_timeout=0, rpt_tag=0, busy=0.
  - req_ready=1 after reset releases.
- States: IDLE, START, RUN, REPORT (2-bit encoding, from package).
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: capture req_tag, clear the cycle counter, load start_cnt=START_CYCLES-1, go to START.
- START:
  - core_start=1.
  - Decrement start_cnt each clock. When start_cnt==0, go to RUN at the next edge.
  - core_ack is ignored in START, because Ack may still be high from the previous program.
- RUN:
  - core_start=0.
  - Each clock: if core_ack=1, go to REPORT with rpt_timeout=0 and rpt_cycles=counter.
  - Else if counter==TIMEOUT-1, go to REPORT with rpt_timeout=1 and rpt_cycles=TIMEOUT.
  - Else increment counter.
  - Ack seen on the first RUN clock gives rpt_cycles=0.
- REPORT:
  - rpt_valid=1; rpt_* are stable while rpt_valid.
  - On rpt_ready, go to IDLE. The earliest a new request can be accepted is the clock after that.
  - The core is left halted; core_start stays 0.
- Latency:
  - Accept edge to first core_start high: 1 clock.
  - Ack edge to rpt_valid high: 1 clock.
- Width rules:
  - The counter is 16 bits and saturates, never wraps.
  - TIMEOUT > 16'hFFFE is clamped to 16'hFFFE at elaboration.
- Simultaneous events:
  - core_ack and timeout in the same RUN clock: Ack wins (rpt_timeout=0).
  - req_valid during REPORT is not accepted (req_ready=0).
- Reset mid-operation: returns immediately to IDLE, drops core_start, and discards the pending report.
- req_valid deasserting before accept is legal; nothing is captured.

Decomposition:
- Package run_seq_pkg holds:
  - the seq_state_t enum {IDLE, START, RUN, REPORT};
  - the localparam CNT_W=16;
  - the saturation constant CNT_MAX=16'hFFFF.
- One natural sub-module, sat_counter (CNT_W bits, clear/enable inputs, saturating output), used for the RUN cycle count.
- The START down-counter stays inline.

Test Plan:
- Reset then req_valid=1, tag=4'h3; core model raises Ack 10 clocks after Start falls.
  - Required: core_start high exactly 2 clocks, then rpt_valid with rpt_cycles=10, rpt_timeout=0, rpt_tag=3.
- Core holds Ack=1 from before the request (stale halt).
  - Required: Ack ignored during START, rpt_cycles=0 on the first RUN clock, no early report during START.
- TIMEOUT=20, core never acks.
  - Required: rpt_timeout=1, rpt_cycles=20, entered REPORT exactly 20 RUN clocks after START.
- Ack and timeout coincide at counter=TIMEOUT-1.
  - Required: rpt_timeout=0, rpt_cycles=TIMEOUT-1.
- Hold rpt_ready=0 for 5 clocks while req_valid=1 with a new tag.
  - Required: rpt_* stable, req_ready=0.
  - After rpt_ready pulses: IDLE, then the new tag is accepted the next clock.
- Assert Reset during RUN at counter=7.
  - Required: core_start=0, rpt_valid=0, busy=0 immediately (async); req_ready=1 after release.
